// File: rtl/pixclk_pkg.sv
// pixclk_pkg: shared constants for the pixel clock divider.
//   DIV_W_DEFAULT       - default width of the divisor / period counter
//   DEFAULT_DIV_DEFAULT - default divisor in force after reset
//   TICK_CNT_W          - width of the optional tick counter output
package pixclk_pkg;

  localparam int unsigned DIV_W_DEFAULT       = 8;
  localparam int unsigned DEFAULT_DIV_DEFAULT = 2;
  localparam int unsigned TICK_CNT_W          = 16;

endpackage : pixclk_pkg

// File: rtl/pixel_clk_gen.sv
// pixel_clk_gen: programmable integer clock divider producing a registered
// divided clock and a one-cycle tick on each of its rising edges. A new divisor
// is only adopted at a period boundary, so phases are never truncated.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   count enable; low freezes the divider
//   div_in       in   requested divisor (DIV_W bits)
//   div_load     in   single-cycle divisor change request
//   div_pending  out  an accepted divisor is waiting for a boundary
//   pixel_clk    out  divided clock (registered)
//   pixel_tick   out  one-cycle pulse with each pixel_clk rising edge
//   tick_count   out  16-bit wrapping tick counter (PIXCLK_TICK_COUNT_EN only)
//
// Build option: define PIXCLK_TICK_COUNT_EN to add the tick_count output.
module pixel_clk_gen
  import pixclk_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_W-1:0]      div_in,
  input  logic                  div_load,
  output logic                  div_pending,
  output logic                  pixel_clk,
  output logic                  pixel_tick
`ifdef PIXCLK_TICK_COUNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_count
`endif
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic [DIV_W-1:0] cur_div_q,  cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q,     pend_d;
  logic             pclk_q,     pclk_d;
  logic             tick_q,     tick_d;

  logic [DIV_W-1:0] half_div;
  logic [DIV_W-1:0] last_cnt;
  logic             degenerate;
  logic             boundary;

  // Period geometry: high phase is floor(N/2); divisors 0 and 1 make every
  // cycle a boundary so pending divisors apply on the next enabled edge.
  assign half_div   = cur_div_q >> 1;
  assign last_cnt   = cur_div_q - ONE;
  assign degenerate = (cur_div_q <= ONE);
  assign boundary   = degenerate || (cnt_q == last_cnt);

  // Next-state for counter, divisor handoff and outputs.
  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    pclk_d     = pclk_q;
    tick_d     = 1'b0;

    if (en) begin
      if (cur_div_q == '0) begin
        pclk_d = 1'b0;
        tick_d = 1'b0;
      end else if (cur_div_q == ONE) begin
        pclk_d = 1'b1;
        tick_d = 1'b1;
      end else begin
        pclk_d = (cnt_q < half_div);
        tick_d = (cnt_q == '0);
      end

      if (boundary) begin
        cnt_d = '0;
        // A load landing on the boundary beats any older pending value.
        if (div_load) begin
          cur_div_d = div_in;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          cur_div_d = pend_div_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
        if (div_load) begin
          pend_div_d = div_in;
          pend_d     = 1'b1;
        end
      end
    end else if (div_load) begin
      // Frozen: still accept the request, boundaries are not evaluated.
      pend_div_d = div_in;
      pend_d     = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_div_q  <= RST_DIV;
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      pclk_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      pclk_q     <= pclk_d;
      tick_q     <= tick_d;
    end
  end

  assign div_pending = pend_q;
  assign pixel_clk   = pclk_q;
  assign pixel_tick  = tick_q;

`ifdef PIXCLK_TICK_COUNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  // Counts ticks as they are issued; wraps naturally at all-ones.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_d) begin
      tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_count = tick_cnt_q;
`endif

endmodule : pixel_clk_gen

// File: tb/tb_pixel_clk_gen.sv
// tb_pixel_clk_gen: directed scenarios plus randomized traffic for
// pixel_clk_gen, checked every cycle against a period-queue reference model.
module tb_pixel_clk_gen;
  import pixclk_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic          en;
  logic [DW-1:0] div_in;
  logic          div_load;
  logic          div_pending;
  logic          pixel_clk;
  logic          pixel_tick;
`ifdef PIXCLK_TICK_COUNT_EN
  logic [15:0]   tick_count;
`endif

  pixel_clk_gen #(.DIV_W(DW), .DEFAULT_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_pending(div_pending),
    .pixel_clk  (pixel_clk),
    .pixel_tick (pixel_tick)
`ifdef PIXCLK_TICK_COUNT_EN
    ,
    .tick_count (tick_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the remaining cycles of the current period are a queue
  // of {clk,tick} pairs; the period ends when the queue runs dry.
  logic [1:0]  m_q[$];
  int unsigned m_div;
  int unsigned m_pdiv;
  logic        m_pend;
  logic        m_clk;
  logic        m_tick;
  logic [15:0] m_tcnt;

  function automatic void fill(input int unsigned n);
    m_q.delete();
    if (n == 0) m_q.push_back(2'b00);
    else if (n == 1) m_q.push_back(2'b11);
    else for (int unsigned i = 0; i < n; i++) m_q.push_back({i < n / 2, i == 0});
  endfunction

  function automatic void model_reset();
    m_div  = 2;
    m_pdiv = 0;
    m_pend = 1'b0;
    m_clk  = 1'b0;
    m_tick = 1'b0;
    m_tcnt = 16'd0;
    fill(m_div);
  endfunction

  function automatic void model_step(input logic e, input logic l, input int unsigned d);
    logic [1:0] ent;
    if (!e) begin
      m_tick = 1'b0;
      if (l) begin
        m_pdiv = d;
        m_pend = 1'b1;
      end
    end else begin
      ent    = m_q.pop_front();
      m_clk  = ent[1];
      m_tick = ent[0];
      if (m_tick) m_tcnt = m_tcnt + 16'd1;
      if (m_q.size() == 0) begin
        if (l) m_div = d;
        else if (m_pend) m_div = m_pdiv;
        m_pend = 1'b0;
        fill(m_div);
      end else if (l) begin
        m_pdiv = d;
        m_pend = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_clk"},  32'(pixel_clk),   32'(m_clk));
    chk({tag, "_tick"}, 32'(pixel_tick),  32'(m_tick));
    chk({tag, "_pend"}, 32'(div_pending), 32'(m_pend));
`ifdef PIXCLK_TICK_COUNT_EN
    chk({tag, "_tcnt"}, 32'(tick_count),  32'(m_tcnt));
`endif
  endtask

  // One clock: drive, advance, sample 1ns after the edge, compare.
  task automatic cyc(input logic e, input logic l, input logic [DW-1:0] d);
    en       = e;
    div_load = l;
    div_in   = d;
    @(posedge clk);
    #1;
    model_step(e, l, 32'(d));
    chk_model("cyc");
    div_load = 1'b0;
  endtask

  task automatic expect_seq(input string tag, input int n,
                            input logic [15:0] cpat, input logic [15:0] tpat);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk({tag, "_clk"},  32'(pixel_clk),  32'(cpat[i]));
      chk({tag, "_tick"}, 32'(pixel_tick), 32'(tpat[i]));
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_clk"},  32'(pixel_clk),   32'd0);
    chk({tag, "_tick"}, 32'(pixel_tick),  32'd0);
    chk({tag, "_pend"}, 32'(div_pending), 32'd0);
`ifdef PIXCLK_TICK_COUNT_EN
    chk({tag, "_tcnt"}, 32'(tick_count),  32'd0);
`endif
    #1 rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_clk",  32'(pixel_clk),   32'd0);
    chk("rst_tick", 32'(pixel_tick),  32'd0);
    chk("rst_pend", 32'(div_pending), 32'd0);
    rst = 1'b0;

    // Default divide-by-2 straight out of reset.
    expect_seq("s1", 4, 16'b0101, 16'b0101);

    // Load 5 mid-period: pending until the boundary, then 2 high / 3 low.
    cyc(1'b1, 1'b1, 8'd5);
    chk("s2_pend_set", 32'(div_pending), 32'd1);
    cyc(1'b1, 1'b0, 8'd0);
    chk("s2_pend_clr", 32'(div_pending), 32'd0);
    expect_seq("s2", 10, 16'b00011_00011, 16'b00001_00001);

    // 7 then 4 before the boundary: only 4 ever takes effect.
    cyc(1'b1, 1'b1, 8'd7);
    cyc(1'b1, 1'b1, 8'd4);
    chk("s3_pend", 32'(div_pending), 32'd1);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    chk("s3_pend_clr", 32'(div_pending), 32'd0);
    expect_seq("s3", 8, 16'b0011_0011, 16'b0001_0001);

    // Load 3 exactly on the boundary: direct, never pending.
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd3);
    chk("s4_pend", 32'(div_pending), 32'd0);
    expect_seq("s4", 6, 16'b001_001, 16'b001_001);

    // Divisor 0 silences the outputs; divisor 1 gives clk high, tick always.
    cyc(1'b1, 1'b1, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    expect_seq("s5_zero", 4, 16'b0000, 16'b0000);
    cyc(1'b1, 1'b1, 8'd1);
    chk("s5_pend", 32'(div_pending), 32'd0);
    expect_seq("s5_one", 4, 16'b1111, 16'b1111);

    // Freeze mid-period with a load captured, then reset mid-period.
    cyc(1'b1, 1'b1, 8'd6);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, (i == 5) ? 1'b1 : 1'b0, 8'd9);
      chk("s6_hold_clk", 32'(pixel_clk),  32'd1);
      chk("s6_no_tick",  32'(pixel_tick), 32'd0);
    end
    chk("s6_pend_frozen", 32'(div_pending), 32'd1);
    cyc(1'b1, 1'b0, 8'd0);
    chk("s6_pend_kept", 32'(div_pending), 32'd1);
    do_reset("s6_rst");
    expect_seq("s6_post", 6, 16'b010101, 16'b010101);
    chk("s6_pend_post", 32'(div_pending), 32'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
          DW'($urandom_range(0, 9)));
      if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pixel_clk_gen

// File: doc/pixel_clk_gen.md
PIXEL_CLK_GEN -- requirements
Module: pixel_clk_gen

Interface
REQ-001 Parameter DIV_W, default 8: width of the divisor and the period counter.
REQ-002 Parameter DEFAULT_DIV, default 2: divisor in force after reset; 2 gives plain mod-2 toggling.
REQ-003 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port en, input, 1: count enable; low freezes the divider.
REQ-006 Port div_in, input, DIV_W: requested divisor, sampled when div_load is high.
REQ-007 Port div_load, input, 1: single-cycle request to change the divisor.
REQ-008 Port div_pending, output, 1: high while an accepted divisor waits for a period boundary.
REQ-009 Port pixel_clk, output, 1: divided clock, registered.
REQ-010 Port pixel_tick, output, 1: one-cycle enable, registered, marks each pixel_clk rising edge.

Function
REQ-011 Internal cur_div (DIV_W) holds the divisor in force; internal cnt (DIV_W) holds the position in the period, 0..cur_div-1.
REQ-012 With en=1 and cur_div>=2: cnt increments each cycle and wraps from cur_div-1 to 0.
REQ-013 The period boundary is the cycle in which cnt==cur_div-1.
REQ-014 pixel_clk <= (cnt < cur_div/2, floor): high for floor(N/2) cycles, low for ceil(N/2) cycles per period.
REQ-015 pixel_tick <= (cnt==0): exactly one pulse per period, in the same cycle pixel_clk goes high.
REQ-016 With cur_div==1: pixel_clk held 1 and pixel_tick asserted every enabled cycle.
REQ-017 With cur_div==0: divider disabled; cnt held 0, pixel_clk 0, pixel_tick 0.
REQ-018 div_load=1 captures div_in into pend_div and sets div_pending on the next edge.
REQ-019 A further div_load while div_pending is high overwrites pend_div; the last value wins and no error is flagged.
REQ-020 At a period boundary with div_pending=1: cur_div <= pend_div, cnt <= 0, div_pending <= 0.
REQ-021 If div_load coincides with a boundary and div_pending=0: div_in goes directly into cur_div for the next period; div_pending stays 0.
REQ-022 If div_load coincides with a boundary and div_pending=1: div_in takes precedence over the stale pend_div and goes directly into cur_div; div_pending clears.
REQ-023 While cur_div is 0 or 1, every cycle counts as a boundary, so a pending divisor applies on the next enabled edge.
REQ-024 With en=0: cnt, cur_div and pixel_clk hold, pixel_tick is 0, div_load is still captured, and boundaries are not evaluated.
REQ-025 Divisor changes never produce a pixel_clk high or low phase shorter than the old or new phase length.

Reset
REQ-026 On rst=1 asynchronously: cnt=0, cur_div=DEFAULT_DIV, pend_div=0, div_pending=0, pixel_clk=0, pixel_tick=0.
REQ-027 A reset mid-period discards any pending divisor; the first edge after release evaluates cnt=0.

Configuration
REQ-028 Macro PIXCLK_TICK_COUNT_EN, when defined, adds output tick_count (16 bits): it increments on each pixel_tick, wraps at 0xFFFF to 0, and resets to 0.
REQ-029 Without PIXCLK_TICK_COUNT_EN, the tick_count port and its counter are absent; all other behaviour is identical.

Structure
REQ-030 Shared package pixclk_pkg holds the DIV_W default, the DEFAULT_DIV default and the tick_count width constant.
REQ-031 The module is a single flat module with no sub-module; the counter and the update logic are too small to split.

Verification
REQ-032 The bench shall cover each of the following directed scenarios:
- Reset release, DEFAULT_DIV=2, en=1 -> pixel_clk 1,0,1,0 from the first edge; pixel_tick on every other cycle.
- div_in=5 loaded mid-period -> div_pending=1 until the boundary, then a period of 5 cycles with pixel_clk high 2 and low 3; one tick per period.
- div_load of 7 then 4 before the boundary -> cur_div becomes 4; 7 is never applied.
- div_load=1 with div_in=3 at cnt==cur_div-1 and div_pending=0 -> the next period is 3 cycles; div_pending never rises.
- div_in=0 -> outputs low; later div_in=1 -> pixel_clk=1 and pixel_tick every cycle.
- en=0 for 10 cycles mid-period, then rst pulsed mid-period with a load pending -> outputs freeze with no ticks; the reset restores DEFAULT_DIV and clears div_pending.
